// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, int8 limits and assembly states for the MAC requant stage
package mac_pkg;
  localparam int ACC_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B2   = 2'd2,
    ST_B3   = 2'd3
  } asm_state_e;
endpackage

// File: rtl/mac_sync_fifo.sv
// rtl/mac_sync_fifo.sv - DEPTH x W synchronous FIFO with occupancy count; head reads 0 when empty
module mac_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          not_empty,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign not_empty = (cnt != '0);
  assign rdata     = not_empty ? mem[rptr] : '0;

  assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && cnt == '0));
endmodule

// File: rtl/mac_requant_deser.sv
// rtl/mac_requant_deser.sv - reassembles byte-serial accumulators, requantises to int8, queues results
module mac_requant_deser #(
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int SHIFT_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic                       cfg_relu,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic                       frame_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);
  import mac_pkg::*;

  localparam int HI_W = ACC_W - BYTE_W;

  asm_state_e          state;
  logic [HI_W-1:0]     acc_hi;
  logic [ACC_W-1:0]    word_reg;
  logic                word_valid;
  logic [SHIFT_W-1:0]  shift_q;
  logic                relu_q;
  logic                accept;
  logic signed [ACC_W:0] x_ext;
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] y_wide;
  logic [BYTE_W-1:0]   act;

  // Counting the word register against DEPTH guarantees it can always drain next edge
  assign in_ready = (int'(fifo_cnt) + int'(word_valid)) < DEPTH;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc_hi     <= '0;
      word_reg   <= '0;
      word_valid <= 1'b0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (cfg_we) begin
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
      end
      word_valid <= 1'b0;
      if (accept) begin
        if (in_first) begin
          if (state != ST_IDLE) frame_err <= 1'b1;
          acc_hi[2*BYTE_W +: BYTE_W] <= in_data;
          state <= ST_B1;
        end else begin
          case (state)
            ST_IDLE: frame_err <= 1'b1;
            ST_B1: begin
              acc_hi[BYTE_W +: BYTE_W] <= in_data;
              state <= ST_B2;
            end
            ST_B2: begin
              acc_hi[0 +: BYTE_W] <= in_data;
              state <= ST_B3;
            end
            default: begin
              word_reg   <= {acc_hi, in_data};
              word_valid <= 1'b1;
              state      <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // 33-bit rounding shift: the half-LSB bias cannot overflow a 32-bit signed input
  always_comb begin
    x_ext = $signed({word_reg[ACC_W-1], word_reg});
    if (relu_q && word_reg[ACC_W-1]) x_ext = '0;
    bias = '0;
    if (shift_q != '0) bias = $signed((ACC_W+1)'(1) << (shift_q - SHIFT_W'(1)));
    y_wide = (x_ext + bias) >>> shift_q;
    if (y_wide > INT8_MAX)      act = BYTE_W'(INT8_MAX);
    else if (y_wide < INT8_MIN) act = BYTE_W'(INT8_MIN);
    else                        act = y_wide[BYTE_W-1:0];
  end

  mac_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_valid),
    .wdata     (act),
    .pop       (out_valid & out_ready),
    .rdata     (out_data),
    .not_empty (out_valid),
    .cnt       (fifo_cnt)
  );
endmodule
